// File: rtl/output_stationary_pkg.sv
// Shared constants for the output-stationary arbiter and its accumulation buffer:
// FSM state encodings, burst width and default sizing.
package output_stationary_pkg;

    localparam int NUM_CORES_DEF = 4;
    localparam int DATA_W_DEF    = 16;
    localparam int ACC_W_DEF     = 32;
    localparam int DEPTH_DEF     = 64;
    localparam int ADDR_W_DEF    = 6;
    localparam int BURST_W       = 6;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] UNLOAD  = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

endpackage

// File: rtl/output_accum_buffer_regfile.sv
// DEPTH x ACC_W accumulator storage: one combinational read port,
// one synchronous write port, synchronous clear-all on reset.
module acc_regfile #(
    parameter int DEPTH  = 64,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [ACC_W-1:0]  rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [ACC_W-1:0]  wr_data_i
);

    logic [ACC_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/output_accum_buffer.sv
// Partial-sum buffer behind the output-stationary arbiter: accumulates core
// bursts into acc_regfile, or streams entries out while clearing them.
module output_accum_buffer
    import output_stationary_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        grant,
    input  logic [BURST_W-1:0]          burst,
    input  logic                        add_en,
    input  logic                        unload_en,
    input  logic [ADDR_W-1:0]           start_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_data,
    input  logic [NUM_CORES-1:0]        core_valid,
    output logic [NUM_CORES-1:0]        core_ready,
    output logic [ACC_W-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        done,
    output logic                        err,
    output logic [1:0]                  dbg_state
);

    localparam int SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [1:0]         state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [SEL_W-1:0]   grant_idx;
    logic               grant_ok;
    logic [DATA_W-1:0]  data_sel;
    logic [ACC_W-1:0]   data_ext;
    logic               core_beat;
    logic               out_beat;
    logic [ACC_W-1:0]   rd_data;
    logic               wr_en;
    logic [ACC_W-1:0]   wr_data;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                grant_idx = SEL_W'(i);
            end
        end
    end

    assign grant_ok = $onehot(grant);

    // Handshakes: a beat moves only in a cycle where valid and ready are both 1;
    // valid never waits on ready, and the producer holds data stable until the beat.
    assign core_ready = (state_q == ACCUM) ? (NUM_CORES'(1) << sel_q) : '0;
    assign core_beat  = |(core_valid & core_ready);
    assign out_valid  = (state_q == UNLOAD);
    assign out_beat   = out_valid & out_ready;
    assign out_data   = out_valid ? rd_data : '0;

    assign data_sel = core_data[sel_q*DATA_W +: DATA_W];
    assign data_ext = {{(ACC_W-DATA_W){data_sel[DATA_W-1]}}, data_sel};

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        burst_d = burst_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_data = '0;
        case (state_q)
            IDLE: begin
                if (grant != '0) begin
                    sel_d   = grant_idx;
                    burst_d = burst;
                    ptr_d   = start_addr;
                    count_d = '0;
                    if (!grant_ok || (add_en == unload_en)) begin
                        err_d   = 1'b1;
                        state_d = RELEASE;
                    end else if (burst == '0) begin
                        done_d  = 1'b1;
                        state_d = RELEASE;
                    end else if (add_en) begin
                        state_d = ACCUM;
                    end else begin
                        state_d = UNLOAD;
                    end
                end
            end
            ACCUM: begin
                if (core_beat) begin
                    wr_en   = 1'b1;
                    wr_data = rd_data + data_ext;
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_d == burst_q) begin
                        done_d  = 1'b1;
                        state_d = RELEASE;
                    end
                end
            end
            UNLOAD: begin
                if (out_beat) begin
                    wr_en   = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_d == burst_q) begin
                        done_d  = 1'b1;
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                // A grant still held from the finished transaction must not retrigger.
                if (grant == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            burst_q <= '0;
            count_q <= '0;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            burst_q <= burst_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    acc_regfile #(
        .DEPTH  (DEPTH),
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_i (ptr_q),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_en),
        .wr_addr_i (ptr_q),
        .wr_data_i (wr_data)
    );

    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
